// File: rtl/alu_result_fifo.sv
// Capture FIFO for ALU results: tags each pushed result with zero/negative/16-bit-overflow
// flags and presents the oldest entry first-word-fall-through on the Out_* ports.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             In_valid,
    output logic                             In_ready,
    input  logic signed [WIDTH-1:0]          Result,
    input  logic [2:0]                       Op_code,
    output logic                             Out_valid,
    input  logic                             Out_ready,
    output logic signed [WIDTH-1:0]          Out_result,
    output logic [2:0]                       Out_op_code,
    output logic                             Out_zero,
    output logic                             Out_neg,
    output logic                             Out_ovf16,
    output logic [$clog2(DEPTH+1)-1:0]       Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [2:0]       op;
        logic             zero;
        logic             neg;
        logic             ovf16;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          entry_d;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic [WIDTH-16:0] upper_bits;

    assign In_ready  = (count_q < CW'(DEPTH)) && !Rst;
    assign Out_valid = (count_q != '0);
    assign push      = In_valid && In_ready;
    assign pop       = Out_valid && Out_ready;

    // Result fits in 16 signed bits only when bits [WIDTH-1:15] are all copies of the sign.
    assign upper_bits    = Result[WIDTH-1:15];
    assign entry_d.res   = Result;
    assign entry_d.op    = Op_code;
    assign entry_d.zero  = (Result == '0);
    assign entry_d.neg   = Result[WIDTH-1];
    assign entry_d.ovf16 = ~((&upper_bits) | ~(|upper_bits));

    assign head        = mem_q[rd_ptr_q];
    assign Out_result  = head.res;
    assign Out_op_code = head.op;
    assign Out_zero    = head.zero;
    assign Out_neg     = head.neg;
    assign Out_ovf16   = head.ovf16;
    assign Count       = count_q;

    // NOTE: combinational next-state logic uses blocking '=' with defaults first so no
    // latch is inferred; the registers below take these values with non-blocking '<='.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is reset too, so the Out_* ports read all-zero after reset
            // rather than stale contents; this costs reset routing on every entry.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) mem_q[wr_ptr_q] <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed and random back-pressure bench for alu_result_fifo (DEPTH=4, WIDTH=32).
module tb_alu_result_fifo;

    logic               Clk = 1'b0;
    logic               Rst;
    logic               In_valid;
    logic               In_ready;
    logic signed [31:0] Result;
    logic [2:0]         Op_code;
    logic               Out_valid;
    logic               Out_ready;
    logic signed [31:0] Out_result;
    logic [2:0]         Out_op_code;
    logic               Out_zero;
    logic               Out_neg;
    logic               Out_ovf16;
    logic [2:0]         Count;

    int n_cmp = 0;
    int n_err = 0;

    alu_result_fifo #(.DEPTH(4), .WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(In_ready),
        .Result(Result), .Op_code(Op_code), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Out_result(Out_result), .Out_op_code(Out_op_code), .Out_zero(Out_zero),
        .Out_neg(Out_neg), .Out_ovf16(Out_ovf16), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (Out_valid !== 1'b0 || Count !== 3'd0 || In_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: valid=%b count=%0d ready=%b, want 0/0/0", Out_valid, Count, In_ready);
        end
        n_cmp++;
        if (Out_result !== 32'sd0 || Out_op_code !== 3'd0 || {Out_zero, Out_neg, Out_ovf16} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_data: res=%0d op=%0d flags=%b, want 0/0/000", Out_result, Out_op_code,
                     {Out_zero, Out_neg, Out_ovf16});
        end
        step();
        Rst = 1'b0;
        #1;
        n_cmp++;
        if (In_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got %b want 1", In_ready);
        end
    endtask

    task automatic test_first_push();
        In_valid = 1'b1; Result = 32'sd5; Op_code = 3'b000; Out_ready = 1'b0;
        step();
        In_valid = 1'b0;
        n_cmp++;
        if (Out_valid !== 1'b1 || Out_result !== 32'sd5 || Out_op_code !== 3'd0 || Count !== 3'd1 ||
            {Out_zero, Out_neg, Out_ovf16} !== 3'b000) begin
            n_err++;
            $display("FAIL first_push: valid=%b res=%0d op=%0d count=%0d flags=%b, want 1/5/0/1/000",
                     Out_valid, Out_result, Out_op_code, Count, {Out_zero, Out_neg, Out_ovf16});
        end
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
        n_cmp++;
        if (Count !== 3'd0 || Out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_pop: count=%0d valid=%b, want 0/0", Count, Out_valid);
        end
    endtask

    task automatic test_fill();
        logic signed [31:0] vals  [4] = '{32'sd0, -32'sd1, 32'sd32768, -32'sd32769};
        logic [2:0]         flags [4] = '{3'b100, 3'b010, 3'b001, 3'b011};
        for (int i = 0; i < 4; i++) begin
            In_valid = 1'b1; Result = vals[i]; Op_code = 3'(i + 1);
            step();
        end
        In_valid = 1'b0;
        n_cmp++;
        if (Count !== 3'd4 || In_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: count=%0d ready=%b, want 4/0", Count, In_ready);
        end
        In_valid = 1'b1; Result = 32'sd99; Op_code = 3'd7;
        step();
        In_valid = 1'b0;
        n_cmp++;
        if (Count !== 3'd4) begin
            n_err++;
            $display("FAIL fill_ignored_push: count=%0d want 4", Count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (Out_valid !== 1'b1 || Out_result !== vals[i] || Out_op_code !== 3'(i + 1) ||
                {Out_zero, Out_neg, Out_ovf16} !== flags[i]) begin
                n_err++;
                $display("FAIL fill_pop%0d: valid=%b res=%0d op=%0d flags=%b, want 1/%0d/%0d/%b", i,
                         Out_valid, Out_result, Out_op_code, {Out_zero, Out_neg, Out_ovf16},
                         vals[i], i + 1, flags[i]);
            end
            Out_ready = 1'b1;
            step();
            Out_ready = 1'b0;
            if (i == 0) begin
                n_cmp++;
                if (In_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL fill_ready_after_pop: got %b want 1", In_ready);
                end
            end
        end
        n_cmp++;
        if (Count !== 3'd0 || Out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fill_drained: count=%0d valid=%b, want 0/0", Count, Out_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic signed [31:0] exp_head;
        for (int i = 0; i < 2; i++) begin
            In_valid = 1'b1; Result = 32'(100 + i); Op_code = 3'd2;
            step();
        end
        for (int i = 1; i <= 10; i++) begin
            In_valid = 1'b1; Result = 32'(i); Op_code = 3'd3; Out_ready = 1'b1;
            exp_head = (i <= 2) ? 32'(99 + i) : 32'(i - 2);
            n_cmp++;
            if (Out_valid !== 1'b1 || Out_result !== exp_head) begin
                n_err++;
                $display("FAIL sim_head%0d: valid=%b res=%0d, want 1/%0d", i, Out_valid, Out_result, exp_head);
            end
            step();
            n_cmp++;
            if (Count !== 3'd2) begin
                n_err++;
                $display("FAIL sim_count%0d: got %0d want 2", i, Count);
            end
        end
        In_valid = 1'b0;
        for (int i = 9; i <= 10; i++) begin
            n_cmp++;
            if (Out_valid !== 1'b1 || Out_result !== 32'(i)) begin
                n_err++;
                $display("FAIL sim_drain%0d: valid=%b res=%0d, want 1/%0d", i, Out_valid, Out_result, i);
            end
            step();
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_idle_empty();
        logic [1:0] rd0, wr0;
        rd0 = dut.rd_ptr_q;
        wr0 = dut.wr_ptr_q;
        Out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (Out_valid !== 1'b0 || Count !== 3'd0) begin
                n_err++;
                $display("FAIL idle%0d: valid=%b count=%0d, want 0/0", i, Out_valid, Count);
            end
        end
        n_cmp++;
        if (dut.rd_ptr_q !== rd0 || dut.wr_ptr_q !== wr0) begin
            n_err++;
            $display("FAIL idle_ptrs: rd=%0d wr=%0d, want rd=%0d wr=%0d", dut.rd_ptr_q, dut.wr_ptr_q, rd0, wr0);
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            In_valid = 1'b1; Result = 32'(11 + i); Op_code = 3'd1;
            step();
        end
        In_valid = 1'b0;
        n_cmp++;
        if (Count !== 3'd3) begin
            n_err++;
            $display("FAIL mid_pre_count: got %0d want 3", Count);
        end
        #2;
        Rst = 1'b1;
        #1;
        n_cmp++;
        if (Out_valid !== 1'b0 || Count !== 3'd0 || In_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async: valid=%b count=%0d ready=%b, want 0/0/0", Out_valid, Count, In_ready);
        end
        In_valid = 1'b1; Result = 32'sd55;
        step();
        Rst = 1'b0;
        Result = 32'sd7; Op_code = 3'd6;
        step();
        In_valid = 1'b0;
        n_cmp++;
        if (Out_valid !== 1'b1 || Out_result !== 32'sd7 || Out_op_code !== 3'd6 || Count !== 3'd1) begin
            n_err++;
            $display("FAIL mid_first: valid=%b res=%0d op=%0d count=%0d, want 1/7/6/1",
                     Out_valid, Out_result, Out_op_code, Count);
        end
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
    endtask

    function automatic logic [2:0] ref_flags(input logic signed [31:0] v);
        ref_flags = {v == 0, v < 0, (v < -32768) || (v > 32767)};
    endfunction

    task automatic test_random();
        logic signed [31:0] q_res [$];
        logic [2:0]         q_op  [$];
        logic signed [31:0] corner [4] = '{32'sd32767, 32'sd32768, -32'sd32768, -32'sd32769};
        int  sent = 0;
        bit  holding = 0;
        bit  push_m, pop_m;
        int  cyc = 0;
        while (cyc < 20000 && !(sent == 1000 && q_res.size() == 0)) begin
            if (!holding && sent < 1000 && $urandom_range(0, 3) != 0) begin
                holding = 1;
                case ($urandom_range(0, 3))
                    0:       Result = 32'sd0;
                    1:       Result = $signed(32'($urandom_range(0, 65535))) - 32'sd32768;
                    2:       Result = $signed($urandom);
                    default: Result = corner[$urandom_range(0, 3)];
                endcase
                Op_code = 3'($urandom_range(0, 7));
            end
            In_valid  = holding;
            Out_ready = ($urandom_range(0, 2) != 0);
            n_cmp++;
            if (In_ready !== (q_res.size() < 4) || Out_valid !== (q_res.size() != 0) ||
                Count !== 3'(q_res.size())) begin
                n_err++;
                $display("FAIL rnd_ctrl cyc%0d: ready=%b valid=%b count=%0d, model size %0d",
                         cyc, In_ready, Out_valid, Count, q_res.size());
            end
            if (q_res.size() != 0) begin
                n_cmp++;
                if (Out_result !== q_res[0] || Out_op_code !== q_op[0] ||
                    {Out_zero, Out_neg, Out_ovf16} !== ref_flags(q_res[0])) begin
                    n_err++;
                    $display("FAIL rnd_head cyc%0d: res=%0d op=%0d flags=%b, want %0d/%0d/%b", cyc,
                             Out_result, Out_op_code, {Out_zero, Out_neg, Out_ovf16},
                             q_res[0], q_op[0], ref_flags(q_res[0]));
                end
            end
            push_m = holding && (q_res.size() < 4);
            pop_m  = (q_res.size() != 0) && Out_ready;
            step();
            if (pop_m) begin
                void'(q_res.pop_front());
                void'(q_op.pop_front());
            end
            if (push_m) begin
                q_res.push_back(Result);
                q_op.push_back(Op_code);
                sent++;
                holding = 0;
            end
            cyc++;
        end
        In_valid = 1'b0;
        Out_ready = 1'b0;
        n_cmp++;
        if (sent != 1000 || q_res.size() != 0) begin
            n_err++;
            $display("FAIL rnd_timeout: sent=%0d pending=%0d, want 1000/0", sent, q_res.size());
        end
    endtask

    initial begin
        Rst = 1'b1; In_valid = 1'b0; Result = '0; Op_code = '0; Out_ready = 1'b0;
        test_reset();
        test_first_push();
        test_fill();
        test_simultaneous();
        test_idle_empty();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
